// File: rtl/stream_fifo_1clk.sv
// Single-clock stream FIFO with valid/ready handshakes on both sides and a fill-level output.
// The head word falls through combinationally from the register array, so there is one cycle of write-to-read latency.
module stream_fifo_1clk #(
   parameter int Width = 8,
   parameter int Depth = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       din_valid,
   output logic                       din_ready,
   input  logic [Width-1:0]           din_data,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [Width-1:0]           dout_data,
   output logic [$clog2(Depth+1)-1:0] used
);

   localparam int PTR_W = $clog2(Depth);
   localparam int CNT_W = $clog2(Depth + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(Depth - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Depth);

   logic [Width-1:0] mem [Depth];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // Explicit wrap keeps the pointers inside 0..Depth-1 for any Depth.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // A full FIFO refuses writes even when a read drains a slot in the same cycle.
   assign din_ready  = !rst && (used != CNT_FULL);
   assign dout_valid = (used != '0);
   assign dout_data  = mem[rd_ptr];
   assign wr_en      = din_valid && din_ready;
   assign rd_en      = dout_valid && dout_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_next(wr_ptr);
         if (rd_en) rd_ptr <= ptr_next(rd_ptr);
         if (wr_en && !rd_en)
            used <= used + CNT_W'(1);
         else if (rd_en && !wr_en)
            used <= used - CNT_W'(1);
      end
   end

   // Storage is never cleared; the pointers alone define which words are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din_data;
   end

endmodule

// File: tb/tb_stream_fifo_1clk.sv
// Directed bench for stream_fifo_1clk (Width=8, Depth=100) with a small queue model of the stored words.
module tb_stream_fifo_1clk;

   localparam int W = 8;
   localparam int D = 100;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          din_valid;
   logic          din_ready;
   logic [W-1:0]  din_data;
   logic          dout_valid;
   logic          dout_ready;
   logic [W-1:0]  dout_data;
   logic [CW-1:0] used;

   int total = 0;
   int bad = 0;

   logic [W-1:0] q[$];
   int           exp_used = 0;
   bit           last_w, last_r;
   logic [W-1:0] rd_act, rd_exp;

   stream_fifo_1clk #(.Width(W), .Depth(D)) dut (
      .clk(clk), .rst(rst),
      .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
      .used(used)
   );

   always #5 clk = ~clk;

   // Advance one clock: predict the transfers from the model, then sample 1ns after the edge.
   task automatic tick();
      bit w, r;
      w = din_valid && !rst && (exp_used != D);
      r = dout_ready && !rst && (exp_used != 0);
      rd_act = dout_data;
      rd_exp = (q.size() != 0) ? q[0] : '0;
      @(posedge clk);
      if (rst) begin
         q.delete();
         exp_used = 0;
      end else begin
         if (r) void'(q.pop_front());
         if (w) q.push_back(din_data);
         exp_used = q.size();
      end
      last_w = w;
      last_r = r;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din_data = '0;
      tick(); tick();
      total++;
      if (din_ready !== 1'b0) begin
         bad++; $display("FAIL reset_din_ready_in_rst got=%0b want=0", din_ready);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (used !== 0 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got used=%0d dv=%0b dr=%0b want used=0 dv=0 dr=1",
                     i, used, dout_valid, din_ready);
         end
         tick();
      end
   endtask

   task automatic test_write_then_read();
      din_valid = 1'b1; dout_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         din_data = W'(i);
         tick();
         total++;
         if (used !== CW'(i) || dout_valid !== 1'b1 || dout_data !== 8'h01) begin
            bad++;
            $display("FAIL wr5_fill i=%0d got used=%0d dv=%0b dd=%h want used=%0d dv=1 dd=01",
                     i, used, dout_valid, dout_data, i);
         end
      end
      din_valid = 1'b0; dout_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         total++;
         if (dout_valid !== 1'b1 || dout_data !== W'(i)) begin
            bad++; $display("FAIL wr5_read i=%0d got dv=%0b dd=%h want dv=1 dd=%h", i, dout_valid, dout_data, W'(i));
         end
         tick();
         total++;
         if (used !== CW'(5 - i)) begin
            bad++; $display("FAIL wr5_used i=%0d got=%0d want=%0d", i, used, 5 - i);
         end
      end
      total++;
      if (dout_valid !== 1'b0) begin
         bad++; $display("FAIL wr5_empty dv got=%0b want=0", dout_valid);
      end
      dout_ready = 1'b0;
   endtask

   task automatic test_fill();
      dout_ready = 1'b0; din_valid = 1'b1;
      for (int i = 0; i < D; i++) begin
         din_data = W'(i);
         tick();
      end
      total++;
      if (used !== CW'(D) || din_ready !== 1'b0 || dout_valid !== 1'b1 || dout_data !== 8'h00) begin
         bad++;
         $display("FAIL fill_full got used=%0d dr=%0b dv=%0b dd=%h want used=100 dr=0 dv=1 dd=00",
                  used, din_ready, dout_valid, dout_data);
      end
      din_data = 8'hAA;
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (used !== CW'(D)) begin
         bad++; $display("FAIL fill_held used got=%0d want=100", used);
      end
      dout_ready = 1'b1;
      total++;
      if (dout_data !== 8'h00) begin
         bad++; $display("FAIL fill_first dd got=%h want=00", dout_data);
      end
      tick();
      total++;
      if (used !== CW'(D - 1) || din_ready !== 1'b1) begin
         bad++; $display("FAIL fill_after_read got used=%0d dr=%0b want used=99 dr=1", used, din_ready);
      end
      dout_ready = 1'b0;
      tick();
      total++;
      if (used !== CW'(D)) begin
         bad++; $display("FAIL fill_refill used got=%0d want=100", used);
      end
      din_valid = 1'b0; dout_ready = 1'b1;
      for (int i = 1; i <= D; i++) begin
         logic [W-1:0] want;
         want = (i == D) ? 8'hAA : W'(i);
         total++;
         if (dout_valid !== 1'b1 || dout_data !== want) begin
            bad++; $display("FAIL fill_drain i=%0d got dv=%0b dd=%h want dv=1 dd=%h", i, dout_valid, dout_data, want);
         end
         tick();
      end
      total++;
      if (used !== 0 || dout_valid !== 1'b0) begin
         bad++; $display("FAIL fill_drained got used=%0d dv=%0b want used=0 dv=0", used, dout_valid);
      end
      dout_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      din_valid = 1'b1; dout_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         din_data = W'(i % 256);
         if (i > 0) begin
            total++;
            if (dout_valid !== 1'b1 || dout_data !== W'((i - 1) % 256)) begin
               bad++;
               $display("FAIL stream_data i=%0d got dv=%0b dd=%h want dv=1 dd=%h",
                        i, dout_valid, dout_data, W'((i - 1) % 256));
            end
         end
         tick();
         total++;
         if (used !== CW'(1)) begin
            bad++; $display("FAIL stream_used i=%0d got=%0d want=1", i, used);
         end
      end
      din_valid = 1'b0;
      total++;
      if (dout_data !== 8'h2B) begin
         bad++; $display("FAIL stream_last dd got=%h want=2b", dout_data);
      end
      tick();
      total++;
      if (used !== 0) begin
         bad++; $display("FAIL stream_end used got=%0d want=0", used);
      end
      dout_ready = 1'b0;
   endtask

   task automatic test_random();
      int nw = 0, nr = 0, cyc = 0;
      while ((nw < 1000 || nr < 1000) && cyc < 20000) begin
         din_valid  = (nw < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         din_data   = W'($urandom);
         dout_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
         if (last_w) nw++;
         if (last_r) begin
            nr++;
            total++;
            if (rd_act !== rd_exp) begin
               bad++; $display("FAIL rand_data n=%0d got=%h want=%h", nr, rd_act, rd_exp);
            end
         end
         total++;
         if (used !== CW'(nw - nr) || used > CW'(D) || dout_valid !== (nw != nr)) begin
            bad++;
            $display("FAIL rand_used cyc=%0d got used=%0d dv=%0b want used=%0d", cyc, used, dout_valid, nw - nr);
         end
      end
      total++;
      if (nw != 1000 || nr != 1000) begin
         bad++; $display("FAIL rand_timeout got wr=%0d rd=%0d want 1000/1000", nw, nr);
      end
      din_valid = 1'b0; dout_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      din_valid = 1'b1; dout_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         din_data = W'(8'h10 + i);
         tick();
      end
      total++;
      if (used !== CW'(7)) begin
         bad++; $display("FAIL mid_pre used got=%0d want=7", used);
      end
      rst = 1'b1; din_data = 8'h99;
      tick();
      total++;
      if (used !== 0 || dout_valid !== 1'b0 || din_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got used=%0d dv=%0b dr=%0b want used=0 dv=0 dr=0", used, dout_valid, din_ready);
      end
      rst = 1'b0; din_data = 8'h55;
      #1;
      total++;
      if (din_ready !== 1'b1) begin
         bad++; $display("FAIL mid_ready got=%0b want=1", din_ready);
      end
      tick();
      din_valid = 1'b0;
      total++;
      if (used !== CW'(1) || dout_valid !== 1'b1 || dout_data !== 8'h55) begin
         bad++;
         $display("FAIL mid_first got used=%0d dv=%0b dd=%h want used=1 dv=1 dd=55", used, dout_valid, dout_data);
      end
      dout_ready = 1'b1;
      tick();
      total++;
      if (used !== 0 || dout_valid !== 1'b0) begin
         bad++; $display("FAIL mid_drain got used=%0d dv=%0b want used=0 dv=0", used, dout_valid);
      end
      dout_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din_data = '0;
      #1;
      test_reset();
      test_write_then_read();
      test_fill();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
